// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues one double-word I-mem request
// at a time and pushes each returned instruction into the instruction buffer.
package fetch_unit_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned MEM_W = 64;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
  } IF_IB_PACKET;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ib_full,
  input  logic             redirect_valid_in,
  input  logic [XLEN-1:0]  redirect_pc_in,
  output logic             proc2Imem_valid,
  output logic [XLEN-1:0]  proc2Imem_addr,
  input  logic             Imem2proc_ack,
  input  logic             Imem2proc_valid,
  input  logic [MEM_W-1:0] Imem2proc_data,
  output IF_IB_PACKET      if_ib_packet
);

  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] hold_inst, hold_inst_next;
  logic [XLEN-1:0] hold_pc, hold_pc_next;
  logic            req_valid_next;
  logic [XLEN-1:0] req_addr_next;
  IF_IB_PACKET     pkt_next;

  // Next-state, next-PC and hold-register capture; redirect wins over every other event.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    hold_inst_next = hold_inst;
    hold_pc_next   = hold_pc;
    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect_valid_in) pc_next = redirect_pc_in;
      end
      REQ: begin
        if (redirect_valid_in) begin
          pc_next    = redirect_pc_in;
          state_next = Imem2proc_ack ? DRAIN : REQ;
        end else if (Imem2proc_ack) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid_in) begin
          pc_next    = redirect_pc_in;
          state_next = Imem2proc_valid ? REQ : DRAIN;
        end else if (Imem2proc_valid) begin
          hold_inst_next = pc[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0];
          hold_pc_next   = pc;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid_in) begin
          pc_next    = redirect_pc_in;
          state_next = REQ;
        end else if (!ib_full) begin
          pc_next    = pc + INST_BYTES;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid_in) pc_next = redirect_pc_in;
        // The stale response retires the only outstanding request, even if a
        // redirect lands in the same cycle; otherwise nothing would ever arrive.
        if (Imem2proc_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, so the ports come straight from flops.
  always_comb begin
    req_valid_next = 1'b0;
    req_addr_next  = '0;
    pkt_next       = '0;
    if (state_next == REQ) begin
      req_valid_next = 1'b1;
      req_addr_next  = {pc_next[XLEN-1:3], 3'b000};
    end
    if (state_next == HOLD) begin
      pkt_next.valid = 1'b1;
      pkt_next.inst  = hold_inst_next;
      pkt_next.PC    = hold_pc_next;
      pkt_next.NPC   = hold_pc_next + INST_BYTES;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      hold_inst       <= '0;
      hold_pc         <= '0;
      proc2Imem_valid <= 1'b0;
      proc2Imem_addr  <= '0;
      if_ib_packet    <= '0;
    end else begin
      state           <= state_next;
      pc              <= pc_next;
      hold_inst       <= hold_inst_next;
      hold_pc         <= hold_pc_next;
      proc2Imem_valid <= req_valid_next;
      proc2Imem_addr  <= req_addr_next;
      if_ib_packet    <= pkt_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-memory model, expected-packet scoreboard,
// directed scenarios followed by randomized redirects, back-pressure and latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ib_full;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        proc2Imem_valid;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_ack;
  logic        Imem2proc_valid;
  logic [63:0] Imem2proc_data;
  IF_IB_PACKET if_ib_packet;

  int errs   = 0;
  int checks = 0;
  int n_push = 0;
  int lat_cfg = 1;
  bit rand_mem = 1'b0;
  IF_IB_PACKET exp_q[$];

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .ib_full          (ib_full),
    .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in   (redirect_pc_in),
    .proc2Imem_valid  (proc2Imem_valid),
    .proc2Imem_addr   (proc2Imem_addr),
    .Imem2proc_ack    (Imem2proc_ack),
    .Imem2proc_valid  (Imem2proc_valid),
    .Imem2proc_data   (Imem2proc_data),
    .if_ib_packet     (if_ib_packet)
  );

  always #5 clock = ~clock;

  // Program image: the double-word at RESET_PC is the fixed pattern, the rest is hashed.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a[31:3] == RST_PC[31:3]) return a[2] ? 32'hAAAA0000 : 32'h11110000;
    return {a[15:0], a[31:16]} ^ 32'h5EEDC0DE;
  endfunction

  function automatic IF_IB_PACKET model_pkt(input logic [31:0] pc);
    IF_IB_PACKET p;
    p.valid = 1'b1;
    p.inst  = word_at(pc);
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: one outstanding request, random or fixed latency, stray valids when idle.
  initial begin : mem_model
    int aw;
    int cnt;
    bit busy;
    logic [31:0] ra;
    aw = 0; cnt = 0; busy = 1'b0; ra = '0;
    Imem2proc_ack = 1'b0; Imem2proc_valid = 1'b0; Imem2proc_data = '0;
    forever begin
      @(posedge clock); #1;
      Imem2proc_ack   = 1'b0;
      Imem2proc_valid = 1'b0;
      Imem2proc_data  = {$urandom(), $urandom()};
      if (!reset_n) begin
        busy = 1'b0;
        aw   = 0;
      end else if (busy) begin
        if (cnt == 0) begin
          Imem2proc_valid = 1'b1;
          Imem2proc_data  = {word_at(ra + 32'd4), word_at(ra)};
          busy = 1'b0;
        end else cnt--;
      end else if (proc2Imem_valid && aw == 0) begin
        Imem2proc_ack = 1'b1;
        ra   = proc2Imem_addr;
        busy = 1'b1;
        cnt  = rand_mem ? int'($urandom_range(2, 0)) : lat_cfg - 1;
        aw   = rand_mem ? int'($urandom_range(2, 0)) : 0;
      end else begin
        if (proc2Imem_valid) aw--;
        if (rand_mem && (proc2Imem_valid || if_ib_packet.valid) && $urandom_range(4, 0) == 0)
          Imem2proc_valid = 1'b1;
      end
    end
  end

  // Scoreboard monitor: request address on every accepted request, packet on every push.
  always @(negedge clock) begin : monitor
    IF_IB_PACKET p;
    if (reset_n) begin
      if (proc2Imem_valid && Imem2proc_ack && !redirect_valid_in)
        check("req_addr", proc2Imem_addr, {exp_q[0].PC[31:3], 3'b000});
      if (redirect_valid_in) begin
        exp_q.delete();
        exp_q.push_back(model_pkt(redirect_pc_in));
      end else if (if_ib_packet.valid && !ib_full) begin
        p = exp_q.pop_front();
        check("push_pkt", if_ib_packet, p);
        n_push++;
        exp_q.push_back(model_pkt(p.PC + 32'd4));
      end
    end
  end

  always @(negedge reset_n) begin
    exp_q.delete();
    exp_q.push_back(model_pkt(RST_PC));
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock); #2;
  endtask

  // Advance cycle by cycle until the selected event is visible; bounded.
  task automatic wait_until(input int what, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      case (what)
        0:       ok = Imem2proc_ack;
        1:       ok = if_ib_packet.valid;
        2:       ok = Imem2proc_valid;
        default: ok = proc2Imem_valid;
      endcase
    end
    check({"wait_", name}, ok, 1);
  endtask

  initial begin : stim
    logic [7:0]  rv, pv;
    logic [31:0] av [8];
    IF_IB_PACKET pc_cap [8];
    reset_n = 1'b0; ib_full = 1'b0; redirect_valid_in = 1'b0; redirect_pc_in = '0;
    exp_q.push_back(model_pkt(RST_PC));
    repeat (3) @(posedge clock);
    #2;
    check("rst_pkt", if_ib_packet, 0);
    check("rst_req", proc2Imem_valid, 0);
    check("rst_addr", proc2Imem_addr, 0);

    // Reset release: 1 IDLE cycle, then REQ/WAIT/HOLD at full rate.
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      rv[i] = proc2Imem_valid;
      pv[i] = if_ib_packet.valid;
      av[i] = proc2Imem_addr;
      pc_cap[i] = if_ib_packet;
    end
    check("req_pattern", rv, 8'h92);
    check("pkt_pattern", pv, 8'h48);
    check("first_addr", av[1], 32'h100);
    check("second_addr", av[4], 32'h100);
    check("first_pkt", pc_cap[3], {1'b1, 32'h11110000, 32'h100, 32'h104});
    check("second_pkt", pc_cap[6], {1'b1, 32'hAAAA0000, 32'h104, 32'h108});

    // Back-pressure: packet held for 5 cycles, no new request.
    wait_until(1, "hold");
    ib_full = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_pkt", if_ib_packet, model_pkt(32'h108));
      check("stall_noreq", proc2Imem_valid, 0);
      step();
    end
    ib_full = 1'b0;
    lat_cfg = 3;

    // Redirect in WAIT with the response 2 cycles later.
    wait_until(0, "ack_wait_redir");
    step();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h400;
    step();
    redirect_valid_in = 1'b0;
    lat_cfg = 1;
    @(negedge clock);
    check("drain_noreq0", proc2Imem_valid, 0);
    step();
    @(negedge clock);
    check("drain_noreq1", proc2Imem_valid, 0);
    check("drain_nopkt", if_ib_packet.valid, 0);
    step();
    check("post_drain_req", proc2Imem_valid, 1);
    check("post_drain_addr", proc2Imem_addr, 32'h400);

    // Redirect in the same cycle as the response.
    wait_until(2, "resp_redir");
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h200;
    step();
    redirect_valid_in = 1'b0;
    check("same_cyc_req", proc2Imem_valid, 1);
    check("same_cyc_addr", proc2Imem_addr, 32'h200);
    check("same_cyc_nopkt", if_ib_packet.valid, 0);

    // Asynchronous reset while holding a packet.
    wait_until(1, "hold_rst");
    ib_full = 1'b1;
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("async_pkt", if_ib_packet, 0);
    check("async_req", proc2Imem_valid, 0);
    step();
    reset_n = 1'b1; ib_full = 1'b0;
    @(negedge clock);
    check("rerst_idle", proc2Imem_valid, 0);
    step();
    check("rerst_req", proc2Imem_valid, 1);
    check("rerst_addr", proc2Imem_addr, RST_PC);

    // Redirect in HOLD to the top of the address space: NPC and next fetch wrap.
    wait_until(1, "hold_wrap");
    redirect_valid_in = 1'b1; redirect_pc_in = 32'hFFFFFFFC;
    step();
    redirect_valid_in = 1'b0;
    check("wrap_nopkt", if_ib_packet.valid, 0);
    check("wrap_req_addr", proc2Imem_addr, 32'hFFFFFFF8);
    wait_until(1, "wrap_pkt");
    check("wrap_pkt", if_ib_packet, {1'b1, word_at(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h0});
    wait_until(3, "wrap_req");
    check("wrap_next_addr", proc2Imem_addr, 32'h0);

    // Randomized traffic with one mid-run reset.
    rand_mem = 1'b1;
    n_push = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      reset_n           = (i != 1500);
      ib_full           = ($urandom_range(99, 0) < 30);
      redirect_valid_in = ($urandom_range(99, 0) < 4);
      redirect_pc_in    = $urandom() & 32'hFFFFFFFC;
    end
    step();
    ib_full = 1'b0; redirect_valid_in = 1'b0;
    repeat (10) step();
    check("random_progress", n_push > 100, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
